// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier:
// controller states, Booth digit selections and the window decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    PX,
    P2X,
    MX,
    M2X
  } digit_sel_e;

  // Map a Booth window {m[2k+1], m[2k], m[2k-1]} to the multiple to add.
  function automatic digit_sel_e booth_decode(input logic [2:0] window);
    digit_sel_e sel;
    case (window)
      3'b001, 3'b010: sel = PX;
      3'b011:         sel = P2X;
      3'b100:         sel = M2X;
      3'b101, 3'b110: sel = MX;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: one window plus the extended
// multiplicand in, one signed partial product (one bit wider) out.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int EXT_W = 10
) (
  input  logic [2:0]       i_window,
  input  logic [EXT_W-1:0] i_mcand,
  output logic [EXT_W:0]   o_pp
);

  digit_sel_e       w_sel;
  logic [EXT_W:0]   w_x;
  logic [EXT_W:0]   w_2x;

  assign w_sel = booth_decode(i_window);
  // The extended multiplicand carries two redundant sign bits, so 2X cannot overflow.
  assign w_x   = {i_mcand[EXT_W-1], i_mcand};
  assign w_2x  = {i_mcand, 1'b0};

  // Select the signed multiple of the multiplicand for this digit.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves o_pp unassigned (no latch).
    o_pp = '0;
    case (w_sel)
      PX:      o_pp = w_x;
      P2X:     o_pp = w_2x;
      MX:      o_pp = -w_x;
      M2X:     o_pp = -w_2x;
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock,
// valid/ready handshake on both the request and the result side.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int   WORD_LEN       = 8,
  parameter logic SIGNED_DEFAULT = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_signed,
  input  logic [WORD_LEN-1:0]     i_multiplier,
  input  logic [WORD_LEN-1:0]     i_multiplicand,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*WORD_LEN-1:0]   o_result
);

  localparam int EXT_W    = WORD_LEN + 2;
  localparam int N_DIGITS = EXT_W / 2;
  localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PROD_W   = 2 * WORD_LEN;
  localparam int PP_W     = EXT_W + 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

  state_e              r_state;
  state_e              w_next_state;
  logic [WORD_LEN-1:0] r_mplr;
  logic [WORD_LEN-1:0] r_mcand;
  logic                r_signed;
  logic [PROD_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROD_W-1:0]   r_result;

  logic [1:0]          w_mplr_ext_bits;
  logic [1:0]          w_mcand_ext_bits;
  logic [EXT_W:0]      w_mplr_x;   // extended multiplier with m[-1]=0 appended
  logic [EXT_W-1:0]    w_mcand_x;
  logic [2:0]          w_window;
  logic [PP_W-1:0]     w_pp;
  logic [PROD_W-1:0]   w_pp_ext;
  logic [PROD_W-1:0]   w_term;
  logic [PROD_W-1:0]   w_sum;
  logic                w_last;

  assign w_mplr_ext_bits  = r_signed ? {2{r_mplr[WORD_LEN-1]}}  : 2'b00;
  assign w_mcand_ext_bits = r_signed ? {2{r_mcand[WORD_LEN-1]}} : 2'b00;
  assign w_mplr_x         = {w_mplr_ext_bits, r_mplr, 1'b0};
  assign w_mcand_x        = {w_mcand_ext_bits, r_mcand};
  assign w_last           = (r_cnt == LAST_DIGIT);

  // Pick the three-bit Booth window for the current digit counter.
  always_comb begin
    w_window = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_cnt == CNT_W'(k)) w_window = w_mplr_x[2*k +: 3];
    end
  end

  booth_pp_gen #(
    .EXT_W (EXT_W)
  ) u_pp_gen (
    .i_window (w_window),
    .i_mcand  (w_mcand_x),
    .o_pp     (w_pp)
  );

  assign w_pp_ext = {{(PROD_W - PP_W){w_pp[PP_W-1]}}, w_pp};
  assign w_term   = w_pp_ext << {r_cnt, 1'b0};
  assign w_sum    = r_acc + w_term;

  // Controller state register.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic: accept in IDLE, step digits in BUSY, hold result in DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_next_state = BUSY;
      BUSY:    if (w_last)  w_next_state = DONE;
      DONE:    if (i_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, digit accumulation and result register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_mplr   <= '0;
      r_mcand  <= '0;
      r_signed <= SIGNED_DEFAULT;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_mplr   <= i_multiplier;
            r_mcand  <= i_multiplicand;
            r_signed <= i_signed;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_result <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign o_ready  = (r_state == IDLE);
  assign o_valid  = (r_state == DONE);
  assign o_result = r_result;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomised checks of booth_mul_seq at WORD_LEN 4, 8 and 16.
// Index 0 -> W=4, 1 -> W=8, 2 -> W=16.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic rstn;
  logic [2:0] t_valid, t_ready, t_signed;
  logic [3:0]  a4,  b4;
  logic [7:0]  a8,  b8;
  logic [15:0] a16, b16;
  logic rdy4, rdy8, rdy16, vld4, vld8, vld16;
  logic [7:0]  res4;
  logic [15:0] res8;
  logic [31:0] res16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WORD_LEN(4)) u_dut4 (
    .i_clk (clk), .i_rstn (rstn), .i_valid (t_valid[0]), .o_ready (rdy4),
    .i_signed (t_signed[0]), .i_multiplier (a4), .i_multiplicand (b4),
    .o_valid (vld4), .i_ready (t_ready[0]), .o_result (res4)
  );

  booth_mul_seq #(.WORD_LEN(8)) u_dut8 (
    .i_clk (clk), .i_rstn (rstn), .i_valid (t_valid[1]), .o_ready (rdy8),
    .i_signed (t_signed[1]), .i_multiplier (a8), .i_multiplicand (b8),
    .o_valid (vld8), .i_ready (t_ready[1]), .o_result (res8)
  );

  booth_mul_seq #(.WORD_LEN(16)) u_dut16 (
    .i_clk (clk), .i_rstn (rstn), .i_valid (t_valid[2]), .o_ready (rdy16),
    .i_signed (t_signed[2]), .i_multiplier (a16), .i_multiplicand (b16),
    .o_valid (vld16), .i_ready (t_ready[2]), .o_result (res16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 8 : 16;
  endfunction

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy4 : (d == 1) ? rdy8 : rdy16;
  endfunction

  function automatic logic get_vld(input int d);
    return (d == 0) ? vld4 : (d == 1) ? vld8 : vld16;
  endfunction

  function automatic logic [31:0] get_res(input int d);
    return (d == 0) ? {24'd0, res4} : (d == 1) ? {16'd0, res8} : res16;
  endfunction

  task automatic set_ops(input int d, input logic [15:0] a, input logic [15:0] b);
    case (d)
      0:       begin a4  = a[3:0]; b4  = b[3:0]; end
      1:       begin a8  = a[7:0]; b8  = b[7:0]; end
      default: begin a16 = a;      b16 = b;      end
    endcase
  endtask

  // Reference product of the W-bit operands, reduced modulo 2^(2W).
  function automatic logic [31:0] ref_prod(input int w, input bit sgn,
                                            input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p, lim;
    logic [63:0] m;
    lim = longint'(1) << w;
    sa  = longint'(a) & (lim - 1);
    sb  = longint'(b) & (lim - 1);
    if (sgn && sa >= lim / 2) sa = sa - lim;
    if (sgn && sb >= lim / 2) sb = sb - lim;
    p = sa * sb;
    m = (64'd1 << (2 * w)) - 64'd1;
    return 32'(64'(p) & m);
  endfunction

  // One full transaction: wait for ready, request, wait for result, stall, retire.
  task automatic do_op(input int d, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                       input int stall, output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!get_rdy(d) && guard < 50) begin step(); guard++; end
    t_signed[d] = sgn;
    set_ops(d, a, b);
    t_valid[d] = 1'b1;
    step();
    t_valid[d] = 1'b0;
    lat = 0;
    while (!get_vld(d) && lat < 60) begin step(); lat++; end
    res = get_res(d);
    repeat (stall) step();
    t_ready[d] = 1'b1;
    step();
    t_ready[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    bit          sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  initial begin
    vec_t        vecs[7];
    logic [31:0] res;
    int          lat;
    int          vcount;

    rstn = 1'b0;
    t_valid = '0; t_ready = '0; t_signed = '0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready_w%0d", width_of(d)),  32'(get_rdy(d)), 32'd1);
      check($sformatf("rst_valid_w%0d", width_of(d)),  32'(get_vld(d)), 32'd0);
      check($sformatf("rst_result_w%0d", width_of(d)), get_res(d),      32'd0);
    end

    // Hand-computed directed vectors, including extreme operands at each width.
    vecs[0] = '{1, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, "s8_m128xm128"};
    vecs[1] = '{1, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, "u8_255x255"};
    vecs[2] = '{1, 1'b1, 16'h00FF, 16'h007F, 32'h0000_FF81, "s8_m1x127"};
    vecs[3] = '{0, 1'b1, 16'h0008, 16'h0008, 32'h0000_0040, "s4_m8xm8"};
    vecs[4] = '{0, 1'b0, 16'h000F, 16'h000F, 32'h0000_00E1, "u4_15x15"};
    vecs[5] = '{2, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "s16_min_x_min"};
    vecs[6] = '{2, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "u16_max_x_max"};
    foreach (vecs[i]) begin
      do_op(vecs[i].d, vecs[i].sgn, vecs[i].a, vecs[i].b, 0, res, lat);
      check(vecs[i].tag, res, vecs[i].exp);
      check({vecs[i].tag, "_lat"}, 32'(lat), 32'(width_of(vecs[i].d) / 2 + 1));
    end

    // Back-pressure in DONE with a new request already waiting.
    do_op(1, 1'b1, 16'h00FF, 16'h007F, 0, res, lat);
    t_signed[1] = 1'b1; set_ops(1, 16'h00FF, 16'h007F);
    t_valid[1] = 1'b1; step(); t_valid[1] = 1'b0;
    lat = 0;
    while (!vld8 && lat < 60) begin step(); lat++; end
    check("bp_lat", 32'(lat), 32'd5);
    t_signed[1] = 1'b1; set_ops(1, 16'h0002, 16'h0003); t_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_c%0d", i),  32'(vld8), 32'd1);
      check($sformatf("bp_result_c%0d", i), {16'd0, res8}, 32'h0000_FF81);
      check($sformatf("bp_ready_c%0d", i),  32'(rdy8), 32'd0);
      step();
    end
    t_ready[1] = 1'b1; step(); t_ready[1] = 1'b0;
    check("retire_ready",  32'(rdy8), 32'd1);
    check("retire_valid",  32'(vld8), 32'd0);
    check("retire_hold",   {16'd0, res8}, 32'h0000_FF81);
    step(); t_valid[1] = 1'b0;
    lat = 0;
    while (!vld8 && lat < 60) begin step(); lat++; end
    check("next_req_lat", 32'(lat), 32'd5);
    check("next_req_res", {16'd0, res8}, 32'h0000_0006);
    t_ready[1] = 1'b1; step(); t_ready[1] = 1'b0;

    // New operands pulsed mid-BUSY must be ignored.
    t_signed[1] = 1'b1; set_ops(1, 16'd10, 16'd20);
    t_valid[1] = 1'b1; step(); t_valid[1] = 1'b0;
    step();
    set_ops(1, 16'd3, 16'd3); t_valid[1] = 1'b1;
    check("busy_ready", 32'(rdy8), 32'd0);
    step(); step(); t_valid[1] = 1'b0;
    lat = 0;
    while (!vld8 && lat < 60) begin step(); lat++; end
    check("busy_ignore_res", {16'd0, res8}, 32'h0000_00C8);
    t_ready[1] = 1'b1; step(); t_ready[1] = 1'b0;

    // Reset while BUSY at digit 2 abandons the operation.
    t_signed[1] = 1'b1; set_ops(1, 16'd10, 16'd20);
    t_valid[1] = 1'b1; step(); t_valid[1] = 1'b0;
    step(); step();
    rstn = 1'b0; step(); rstn = 1'b1;
    check("abort_ready",  32'(rdy8), 32'd1);
    check("abort_valid",  32'(vld8), 32'd0);
    check("abort_result", {16'd0, res8}, 32'd0);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (vld8) vcount++;
      step();
    end
    check("abort_no_valid", 32'(vcount), 32'd0);
    do_op(1, 1'b1, 16'h0003, 16'h00FB, 0, res, lat);
    check("post_rst_3xm5", res, 32'h0000_FFF1);
    check("post_rst_lat", 32'(lat), 32'd5);

    // Random operands, both modes, random result-side stalls, all widths.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 15; n++) begin
        logic [15:0] ra, rb, msk;
        bit          rs;
        int          w;
        w   = width_of(d);
        msk = 16'((32'd1 << w) - 32'd1);
        ra  = 16'($urandom) & msk;
        rb  = 16'($urandom) & msk;
        rs  = 1'($urandom_range(0, 1));
        do_op(d, rs, ra, rb, $urandom_range(0, 3), res, lat);
        check($sformatf("rand_w%0d_%s_%0h_x_%0h", w, rs ? "s" : "u", ra, rb),
              res, ref_prod(w, rs, ra, rb));
        check($sformatf("rand_w%0d_lat", w), 32'(lat), 32'(w / 2 + 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 8, giving operand width; legal values are even integers >= 4.
REQ-002 The block SHALL have parameter SIGNED_DEFAULT, default 1'b1, giving the operand mode latched by reset into the mode shadow register.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rstn  input  1  reset; synchronous, active-low.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  block can accept a request this cycle.
REQ-007 i_signed  input  1  1: operands are two's complement; 0: operands are unsigned; sampled with the request.
REQ-008 i_multiplier  input  WORD_LEN  multiplier operand.
REQ-009 i_multiplicand  input  WORD_LEN  multiplicand operand.
REQ-010 o_valid  output  1  o_result holds a completed product.
REQ-011 i_ready  input  1  consumer accepts o_result.
REQ-012 o_result  output  2*WORD_LEN  product, registered.

Function
REQ-013 The block SHALL implement an iterative radix-4 Booth multiplier retiring one Booth digit per clock.
REQ-014 Operands SHALL be extended to WORD_LEN+2 bits: sign-extended when i_signed=1, zero-extended when i_signed=0.
REQ-015 N_DIGITS SHALL equal (WORD_LEN+2)/2; WORD_LEN=8 gives 5.
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 In IDLE, o_ready SHALL be 1.
REQ-018 In BUSY and DONE, o_ready SHALL be 0.
REQ-019 A request is accepted on a rising edge where i_valid=1 and o_ready=1. On that edge the block SHALL register the operands and i_signed, clear the accumulator and digit counter, and enter BUSY.
REQ-020 i_valid and operand changes SHALL be ignored outside IDLE.
REQ-021 Each BUSY edge SHALL:
- take Booth window {m[2k+1], m[2k], m[2k-1]}, with m[-1]=0, where k is the digit counter;
- select 0, +-X or +-2X of the extended multiplicand;
- add it, shifted left 2k, to the accumulator;
- increment k.
REQ-022 The accumulator SHALL be 2*WORD_LEN bits, two's complement, wrapping modulo 2^(2*WORD_LEN). The result is exact for both modes.
REQ-023 On the BUSY edge with k=N_DIGITS-1, the block SHALL write the final sum to o_result and enter DONE. o_valid therefore rises exactly N_DIGITS clocks after the acceptance edge.
REQ-024 In DONE, o_valid SHALL be 1 and o_result SHALL be held stable until a rising edge with i_ready=1. On that edge the block SHALL return to IDLE and deassert o_valid.
REQ-025 A new request SHALL not be accepted on the same edge that retires a result. The minimum request interval is N_DIGITS+2 clocks.
REQ-026 o_result SHALL retain the last product after o_valid falls, until the next product is written.

Reset
REQ-027 While i_rstn=0 at a rising edge, the block SHALL enter IDLE and clear o_valid, o_result, accumulator, counter and operand registers to 0. The mode register SHALL be set to SIGNED_DEFAULT.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL abandon the operation with no o_valid pulse. o_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-029 A shared package booth_pkg SHALL hold the FSM state enum typedef and the Booth digit-select enum (ZERO, PX, P2X, MX, M2X).
REQ-030 N_DIGITS and derived widths SHALL be localparams in the module.
REQ-031 One sub-module, booth_pp_gen, parametrised by width, SHALL map a 3-bit window and the extended multiplicand to a signed partial product.

Verification
REQ-032 Signed: -128 x -128, W=8 -> o_result=16'h4000, o_valid 5 clocks after acceptance.
REQ-033 Unsigned: 255 x 255 -> 16'hFE01; signed: 8'hFF x 8'h7F -> 16'hFF81 (-127).
REQ-034 Back-pressure: i_ready=0 for 10 cycles in DONE -> o_valid and o_result stable throughout; o_ready=0 until the retire edge plus one.
REQ-035 i_valid pulsed with new operands during BUSY -> ignored; result matches the first request only.
REQ-036 Reset at BUSY digit 2 -> o_valid never asserted and o_result=0. The next request, 3 x -5 signed, gives 16'hFFF1.
REQ-037 Random, W in {4,8,16}, both modes, random i_ready stalls -> every result equals the reference product mod 2^(2W).
